// File: rtl/secuencia_pkg.sv
// Shared types and constants for the arbitrary-sequence counter controller.
// The table entry layout is {valid, next_code}.
package secuencia_pkg;

  localparam int W     = 4;
  localparam int DEPTH = 2 ** W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    HOLD = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  // The power-on table is a plain binary up-count that wraps at the top code.
  function automatic logic [W:0] default_entry(input logic [W-1:0] idx);
    logic [W-1:0] nxt;
    nxt = idx + 1'b1;
    return {1'b1, nxt};
  endfunction

endpackage

// File: rtl/secuencia_ctrl_if.sv
// Host-side bundle of the sequencing controller: run control, table
// programming port and the observed sequence code/status.
interface secuencia_ctrl_if #(
  parameter int CW = 8
) ();
  import secuencia_pkg::*;

  logic          start;
  logic          stop;
  logic [W-1:0]  seed;
  logic [CW-1:0] steps;
  logic [W-1:0]  target;
  logic          use_target;
  logic          tbl_we;
  logic [W-1:0]  tbl_addr;
  logic [W:0]    tbl_data;
  logic [W-1:0]  Q;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, stop, seed, steps, target, use_target,
    output tbl_we, tbl_addr, tbl_data,
    input  Q, busy, done, err
  );

  modport slave (
    input  start, stop, seed, steps, target, use_target,
    input  tbl_we, tbl_addr, tbl_data,
    output Q, busy, done, err
  );

endinterface

// File: rtl/seq_table.sv
// Next-state table: DEPTH x (W+1) register file, synchronous write,
// combinational reads, synchronous reset back to the up-count table.
module seq_table
  import secuencia_pkg::*;
(
  input  logic         C,
  input  logic         R,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [W:0]   wdata,
  input  logic [W-1:0] raddr_a,
  output logic [W:0]   rdata_a,
  input  logic [W-1:0] raddr_b,
  output logic         valid_b
);

  logic [W:0] tbl_q [DEPTH];
  logic [W:0] tbl_d [DEPTH];

  always_comb begin
    tbl_d = tbl_q;
    if (we) begin
      tbl_d[waddr] = wdata;
    end
  end

  // Reset wins over a coincident write.
  always_ff @(posedge C) begin
    if (R) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= default_entry(W'(i));
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign rdata_a = tbl_q[raddr_a];
  assign valid_b = tbl_q[raddr_b][W];

endmodule

// File: rtl/secuencia_ctrl.sv
// Sequencing controller: loads a seed, walks the next-state table one
// transition per clock and stops on a step count, a target code or an illegal entry.
module secuencia_ctrl
  import secuencia_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic           C,
  input  logic           R,
  secuencia_ctrl_if.slave bus
);

  state_e        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [CW-1:0] cnt_inc;
  logic [W:0]    cur_entry;
  logic [W-1:0]  nxt;
  logic          cur_valid;
  logic          seed_valid;
  logic          go;
  logic          step_hit;
  logic          target_hit;

  seq_table u_table (
    .C       (C),
    .R       (R),
    .we      (bus.tbl_we),
    .waddr   (bus.tbl_addr),
    .wdata   (bus.tbl_data),
    .raddr_a (q_q),
    .rdata_a (cur_entry),
    .raddr_b (bus.seed),
    .valid_b (seed_valid)
  );

  assign cur_valid  = cur_entry[W];
  assign nxt        = cur_entry[W-1:0];
  assign cnt_inc    = cnt_q + 1'b1;
  assign go         = bus.start & ~bus.stop;
  assign step_hit   = (bus.steps != '0) && (cnt_inc == bus.steps);
  assign target_hit = bus.use_target && (nxt == bus.target);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (go) begin
          q_d     = bus.seed;
          cnt_d   = '0;
          state_d = seed_valid ? RUN : ERR;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = HOLD;
        end else if (!cur_valid) begin
          state_d = ERR;
        end else begin
          q_d   = nxt;
          cnt_d = cnt_inc;
          if (step_hit || target_hit) begin
            state_d = DONE;
          end
        end
      end
      HOLD: begin
        // Resume does not advance; the first step after resume comes a cycle later.
        if (go) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.busy = (state_q == RUN) || (state_q == HOLD);
  assign bus.done = (state_q == DONE);
  assign bus.err  = (state_q == ERR);

endmodule
